// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared VRAM constants and types for the vblank dirty-block copy scheduler.
//   VRAM_ADDR_W    : VRAM word-address width (64-bit words)
//   VRAM_DATA_W    : VRAM word width
//   VRAM_BLK_LOG2  : log2 of words per dirty-tracking block
//   vram_sync_state_e : sync FSM state encoding
//   vram_blk_idx_t    : block index (upper address bits)
//   vram_blk_of()     : address -> block index helper
// ---------------------------------------------------------------------------
package vram_pkg;

  localparam int VRAM_ADDR_W   = 13;
  localparam int VRAM_DATA_W   = 64;
  localparam int VRAM_BLK_LOG2 = 6;
  localparam int VRAM_BLK_W    = VRAM_ADDR_W - VRAM_BLK_LOG2;
  localparam int VRAM_NUM_BLK  = 1 << VRAM_BLK_W;

  typedef enum logic [1:0] {
    SYNC_IDLE  = 2'd0,
    SYNC_SCAN  = 2'd1,
    SYNC_COPY  = 2'd2,
    SYNC_DRAIN = 2'd3
  } vram_sync_state_e;

  typedef logic [VRAM_BLK_W-1:0] vram_blk_idx_t;

  // Block index that a VRAM word address falls into.
  function automatic vram_blk_idx_t vram_blk_of(input logic [VRAM_ADDR_W-1:0] addr);
    return addr[VRAM_ADDR_W-1:VRAM_BLK_LOG2];
  endfunction

endpackage

// File: rtl/vram_dirty_map.sv
// ---------------------------------------------------------------------------
// vram_dirty_map
// Per-block dirty bitmap for the VRAM sync scheduler.
// Build option: VRAM_SYNC_FULL_COPY_EN -- when defined the bitmap is not
// built and every block reads as dirty.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (all bits -> 1)
//   i_mark_en/idx     : CPU write snoop, sets the block's bit
//   i_test_idx        : block under test; o_test_bit returns its bit
//   i_clr_en          : clears the bit at i_test_idx
//   i_remark_en/idx   : re-sets a bit (block whose copy was cut short)
// A set (mark or re-mark) always wins over a clear of the same bit in the
// same cycle.
// ---------------------------------------------------------------------------
module vram_dirty_map
  import vram_pkg::*;
#(
  parameter int BLK_W = VRAM_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mark_en,
  input  logic [BLK_W-1:0] i_mark_idx,
  input  logic [BLK_W-1:0] i_test_idx,
  output logic             o_test_bit,
  input  logic             i_clr_en,
  input  logic             i_remark_en,
  input  logic [BLK_W-1:0] i_remark_idx
);

  localparam int NUM_BLK = 1 << BLK_W;

`ifdef VRAM_SYNC_FULL_COPY_EN

  // No tracking: every block is always copied.
  assign o_test_bit = 1'b1;

  logic w_unused_map_inputs;
  assign w_unused_map_inputs = ^{clk, rst_n, i_mark_en, i_mark_idx, i_test_idx,
                                 i_clr_en, i_remark_en, i_remark_idx};

`else

  logic [NUM_BLK-1:0] r_dirty;

  // Sets are written after the clear so that they take priority when they
  // hit the same bit in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= '1;
    end else begin
      if (i_clr_en) begin
        r_dirty[i_test_idx] <= 1'b0;
      end
      if (i_remark_en) begin
        r_dirty[i_remark_idx] <= 1'b1;
      end
      if (i_mark_en) begin
        r_dirty[i_mark_idx] <= 1'b1;
      end
    end
  end

  assign o_test_bit = r_dirty[i_test_idx];

`endif

endmodule

// File: rtl/vram_dirty_sync_ctrl.sv
// ---------------------------------------------------------------------------
// vram_dirty_sync_ctrl
// Vblank copy scheduler for the double-buffered VRAM. Snoops CPU writes to
// build a per-block dirty bitmap, and on each sync pulse streams only the
// dirty blocks from CPU-facing to PPU-facing VRAM (read -> write pipeline).
// Build option: VRAM_SYNC_FULL_COPY_EN -- when defined, dirty tracking is
// compiled out and every pass copies all blocks.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_cpu_wren/wraddr    : snooped CPU VRAM writes
//   i_sync               : pulse, start a copy pass (ignored while busy)
//   i_abort              : pulse, stop the pass (vblank end)
//   o_busy               : pass in progress (registered)
//   o_done / o_aborted   : one-cycle end-of-pass pulses (registered)
//   o_c_rden/rdaddr      : CPU-facing VRAM read port
//   i_c_rddata           : CPU-facing read data, RD_LAT cycles after o_c_rden
//   o_p_wren/wraddr/...  : PPU-facing VRAM write port, byte enables all-ones
// ---------------------------------------------------------------------------
module vram_dirty_sync_ctrl
  import vram_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int BLK_LOG2 = VRAM_BLK_LOG2,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cpu_wren,
  input  logic [ADDR_W-1:0]   i_cpu_wraddr,
  input  logic                i_sync,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_aborted,
  output logic                o_c_rden,
  output logic [ADDR_W-1:0]   o_c_rdaddr,
  input  logic [DATA_W-1:0]   i_c_rddata,
  output logic                o_p_wren,
  output logic [ADDR_W-1:0]   o_p_wraddr,
  output logic [DATA_W-1:0]   o_p_wrdata,
  output logic [DATA_W/8-1:0] o_p_byteena
);

  localparam int BLK_W = ADDR_W - BLK_LOG2;

  localparam logic [1:0] ST_IDLE  = SYNC_IDLE;
  localparam logic [1:0] ST_SCAN  = SYNC_SCAN;
  localparam logic [1:0] ST_COPY  = SYNC_COPY;
  localparam logic [1:0] ST_DRAIN = SYNC_DRAIN;

  // Pipe stages that will still produce a write after the current cycle.
  // The last stage is writing right now, so it does not hold DRAIN back.
  localparam logic [RD_LAT-1:0] PEND_MASK = {RD_LAT{1'b1}} >> 1;

  logic [1:0]          r_state;
  logic [1:0]          w_nxt_state;
  logic [BLK_W-1:0]    r_blk_ptr;
  logic [BLK_LOG2-1:0] r_word_ptr;
  logic                r_abort_flag;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;

  logic                w_test_bit;
  logic                w_last_blk;
  logic                w_last_word;
  logic                w_rden;
  logic [ADDR_W-1:0]   w_rdaddr;
  logic                w_clr_en;
  logic                w_remark_en;
  logic                w_finish;
  logic                w_sync_take;
  logic                w_abort_take;
  logic                w_pipe_pending;

  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [ADDR_W-1:0]   r_pipe_addr [RD_LAT];

  logic                w_unused_lo;

  assign w_last_blk   = &r_blk_ptr;
  assign w_last_word  = &r_word_ptr;
  assign w_rdaddr     = {r_blk_ptr, r_word_ptr};
  assign w_sync_take  = (r_state == ST_IDLE) && i_sync;
  assign w_abort_take = ((r_state == ST_SCAN) || (r_state == ST_COPY)) && i_abort;
  assign w_pipe_pending = |(r_pipe_vld & PEND_MASK);

  // Word-within-block bits do not matter for marking.
  assign w_unused_lo = ^i_cpu_wraddr[BLK_LOG2-1:0];

  vram_dirty_map #(
    .BLK_W(BLK_W)
  ) u_dirty_map (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mark_en    (i_cpu_wren),
    .i_mark_idx   (i_cpu_wraddr[ADDR_W-1:BLK_LOG2]),
    .i_test_idx   (r_blk_ptr),
    .o_test_bit   (w_test_bit),
    .i_clr_en     (w_clr_en),
    .i_remark_en  (w_remark_en),
    .i_remark_idx (r_blk_ptr)
  );

  // Next-state and per-cycle control. Abort is checked first in SCAN and
  // COPY so that no read is issued in the abort cycle itself. A block's bit
  // is cleared when SCAN picks it up; if the copy is then cut short by an
  // abort the bit is set again so the next pass repeats the whole block.
  always_comb begin
    w_nxt_state = r_state;
    w_rden      = 1'b0;
    w_clr_en    = 1'b0;
    w_remark_en = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_sync) begin
          w_nxt_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (i_abort) begin
          w_nxt_state = ST_DRAIN;
        end else if (w_test_bit) begin
          w_clr_en    = 1'b1;
          w_nxt_state = ST_COPY;
        end else if (w_last_blk) begin
          w_nxt_state = ST_DRAIN;
        end
      end
      ST_COPY: begin
        if (i_abort) begin
          w_remark_en = 1'b1;
          w_nxt_state = ST_DRAIN;
        end else begin
          w_rden = 1'b1;
          if (w_last_word) begin
            w_nxt_state = w_last_blk ? ST_DRAIN : ST_SCAN;
          end
        end
      end
      ST_DRAIN: begin
        if (!w_pipe_pending) begin
          w_finish    = 1'b1;
          w_nxt_state = ST_IDLE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State, block/word pointers and the abort memory for the current pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_blk_ptr    <= '0;
      r_word_ptr   <= '0;
      r_abort_flag <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (w_sync_take) begin
        r_blk_ptr    <= '0;
        r_abort_flag <= 1'b0;
      end else if (w_abort_take) begin
        r_abort_flag <= 1'b1;
      end else if (r_state == ST_SCAN) begin
        if (w_test_bit) begin
          r_word_ptr <= '0;
        end else if (!w_last_blk) begin
          r_blk_ptr <= r_blk_ptr + 1'b1;
        end
      end else if (r_state == ST_COPY) begin
        r_word_ptr <= r_word_ptr + 1'b1;
        if (w_last_word && !w_last_blk) begin
          r_blk_ptr <= r_blk_ptr + 1'b1;
        end
      end
    end
  end

  // Registered status. busy drops the cycle after the end pulse unless a
  // new sync is accepted in that very cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= w_finish && !r_abort_flag;
      r_aborted <= w_finish && r_abort_flag;
      if (w_sync_take) begin
        r_busy <= 1'b1;
      end else if (r_done || r_aborted) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Read-to-write pipe: carries each read address forward so the matching
  // write lands exactly when the read data comes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_pipe_addr[k] <= '0;
      end
    end else begin
      r_pipe_vld[0]  <= w_rden;
      r_pipe_addr[0] <= w_rdaddr;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipe_vld[k]  <= r_pipe_vld[k-1];
        r_pipe_addr[k] <= r_pipe_addr[k-1];
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;
  assign o_c_rden    = w_rden;
  assign o_c_rdaddr  = w_rdaddr;
  assign o_p_wren    = r_pipe_vld[RD_LAT-1];
  assign o_p_wraddr  = r_pipe_addr[RD_LAT-1];
  assign o_p_wrdata  = o_p_wren ? i_c_rddata : '0;
  assign o_p_byteena = '1;

endmodule

// File: tb/tb_vram_dirty_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vram_dirty_sync_ctrl
// Directed bench for the VRAM dirty-block sync scheduler (RD_LAT = 1).
// A small read model returns an address-derived pattern so every PPU write
// can be tied back to the word it copies.
// ---------------------------------------------------------------------------
module tb_vram_dirty_sync_ctrl;
  import vram_pkg::*;

  localparam int AW  = VRAM_ADDR_W;
  localparam int DW  = VRAM_DATA_W;
  localparam int RDL = 1;

  localparam int KIND_WR    = 0;
  localparam int KIND_SYNC  = 1;
  localparam int KIND_ABORT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cpuWren = 1'b0;
  logic [AW-1:0]   cpuWraddr = '0;
  logic            sync = 1'b0;
  logic            abort = 1'b0;
  logic            busy;
  logic            done;
  logic            aborted;
  logic            cRden;
  logic [AW-1:0]   cRdaddr;
  logic [DW-1:0]   cRddata;
  logic            pWren;
  logic [AW-1:0]   pWraddr;
  logic [DW-1:0]   pWrdata;
  logic [DW/8-1:0] pByteena;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stimCyc = 0;
  int passT = 0;

  int snapWr, snapRd, snapDone, snapAbort, snapData;

  logic [AW-1:0] wrLog[$];
  int            rdCycLog[$];
  int            dataErrs = 0;
  int            doneCnt = 0;
  int            abortCnt = 0;

  logic [AW-1:0] memRdAddr = '0;

  vram_dirty_sync_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .BLK_LOG2(VRAM_BLK_LOG2),
    .RD_LAT  (RDL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cpu_wren  (cpuWren),
    .i_cpu_wraddr(cpuWraddr),
    .i_sync      (sync),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_done      (done),
    .o_aborted   (aborted),
    .o_c_rden    (cRden),
    .o_c_rdaddr  (cRdaddr),
    .i_c_rddata  (cRddata),
    .o_p_wren    (pWren),
    .o_p_wraddr  (pWraddr),
    .o_p_wrdata  (pWrdata),
    .o_p_byteena (pByteena)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] patternOf(input logic [AW-1:0] a);
    return {16'hC0DE, 3'b000, a, 16'hBEEF, 3'b000, ~a};
  endfunction

  // One-cycle-latency CPU-facing VRAM read model.
  always @(posedge clk) begin
    if (cRden) memRdAddr <= cRdaddr;
  end
  assign cRddata = patternOf(memRdAddr);

  // Monitor: samples mid-cycle, logs writes/reads and counts end pulses.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (pWren) begin
        wrLog.push_back(pWraddr);
        if (pWrdata !== patternOf(pWraddr)) dataErrs++;
      end
      if (cRden) rdCycLog.push_back(cyc);
      if (done) doneCnt++;
      if (aborted) abortCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int kind, input logic [AW-1:0] addr);
    @(negedge clk);
    stimCyc = cyc;
    case (kind)
      KIND_WR:    begin cpuWren = 1'b1; cpuWraddr = addr; end
      KIND_SYNC:  sync = 1'b1;
      KIND_ABORT: abort = 1'b1;
      default:    ;
    endcase
    @(negedge clk);
    cpuWren = 1'b0;
    sync    = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic startPass();
    snapWr    = wrLog.size();
    snapRd    = rdCycLog.size();
    snapDone  = doneCnt;
    snapAbort = abortCnt;
    snapData  = dataErrs;
    applyStimulus(KIND_SYNC, '0);
    passT = stimCyc;
    #3;
    checkOutput("busyRise", busy, 1'b1);
  endtask

  task automatic finishPass(input string tag, input int budget, input int expLat, input bit expAbort);
    int endCyc;
    bit seen;
    bit wasAbort;
    bit busyAtEnd;
    endCyc = -1;
    seen = 0;
    wasAbort = 0;
    busyAtEnd = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #3;
      if (done || aborted) begin
        seen = 1;
        endCyc = cyc;
        wasAbort = aborted;
        busyAtEnd = busy;
      end
    end
    checkOutput({tag, "_ended"}, seen, 1'b1);
    checkOutput({tag, "_latency"}, endCyc - passT, expLat);
    checkOutput({tag, "_abortedPulse"}, wasAbort, expAbort);
    checkOutput({tag, "_busyAtEnd"}, busyAtEnd, 1'b1);
    @(negedge clk);
    #3;
    checkOutput({tag, "_busyFall"}, busy, 1'b0);
    checkOutput({tag, "_doneCount"}, doneCnt - snapDone, expAbort ? 0 : 1);
    checkOutput({tag, "_abortCount"}, abortCnt - snapAbort, expAbort ? 1 : 0);
    checkOutput({tag, "_dataErrs"}, dataErrs - snapData, 0);
  endtask

  // Writes since the pass start must be range lo1..lo1+n1-1 then lo2..lo2+n2-1.
  task automatic checkWrites(input string tag, input int lo1, input int n1, input int lo2, input int n2);
    int errs;
    int n;
    int expAddr;
    errs = 0;
    n = wrLog.size() - snapWr;
    checkOutput({tag, "_wrCount"}, n, n1 + n2);
    for (int i = 0; i < n && i < n1 + n2; i++) begin
      expAddr = (i < n1) ? lo1 + i : lo2 + (i - n1);
      if (wrLog[snapWr + i] != expAddr[AW-1:0]) errs++;
    end
    checkOutput({tag, "_wrOrder"}, errs, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #3;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_aborted", aborted, 1'b0);
    checkOutput("rst_cRden", cRden, 1'b0);
    checkOutput("rst_cRdaddr", cRdaddr, '0);
    checkOutput("rst_pWren", pWren, 1'b0);
    checkOutput("rst_pWraddr", pWraddr, '0);
    checkOutput("rst_pWrdata", pWrdata, '0);
    checkOutput("rst_pByteena", pByteena, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pass 1: everything dirty after reset, 128 x 65 cycles, done 2 after last read.
    startPass();
    finishPass("p1", 9000, 8322, 1'b0);
    checkOutput("p1_firstRd", rdCycLog[snapRd] - passT, 2);
    checkWrites("p1", 0, 8192, 0, 0);

    // Pass 2: nothing dirty; SCAN t+1..t+128, DRAIN t+129, done t+130.
    startPass();
    finishPass("p2", 500, 130, 1'b0);
    checkWrites("p2", 0, 0, 0, 0);

    // Abort while idle has no effect.
    applyStimulus(KIND_ABORT, '0);
    repeat (3) @(negedge clk);
    #3;
    checkOutput("idleAbort_count", abortCnt - snapAbort, 0);
    checkOutput("idleAbort_busy", busy, 1'b0);

    // Pass 3: one write into block 1; SCAN b0 t+1, b1 t+2, reads t+3..t+66,
    // blocks 2..127 scanned t+67..t+192, DRAIN t+193, done t+194.
    applyStimulus(KIND_WR, 13'h0045);
    startPass();
    finishPass("p3", 500, 194, 1'b0);
    checkWrites("p3", 'h40, 64, 0, 0);

    // Pass 4: blocks 0 and 127 dirty, abort 10 cycles after first read (t+12).
    applyStimulus(KIND_WR, 13'h0000);
    applyStimulus(KIND_WR, 13'h1FFF);
    startPass();
    repeat (10) @(negedge clk);
    applyStimulus(KIND_ABORT, '0);
    checkOutput("p4_abortCyc", stimCyc - passT, 12);
    finishPass("p4", 100, 14, 1'b1);
    checkOutput("p4_firstRd", rdCycLog[snapRd] - passT, 2);
    checkOutput("p4_rdCount", rdCycLog.size() - snapRd, 10);
    checkWrites("p4", 0, 10, 0, 0);

    // Pass 4b: block 0 (re-marked) and block 127 (never scanned) recopied.
    // b0 reads t+2..t+65, b1..b126 scanned t+66..t+191, b127 SCAN t+192,
    // reads t+193..t+256, DRAIN t+257, done t+258.
    startPass();
    finishPass("p4b", 500, 258, 1'b0);
    checkWrites("p4b", 0, 64, 'h1FC0, 64);

    // Pass 5: CPU writes into block 1 while it is being copied (t+10).
    applyStimulus(KIND_WR, 13'h0042);
    startPass();
    repeat (8) @(negedge clk);
    applyStimulus(KIND_WR, 13'h0042);
    finishPass("p5", 500, 194, 1'b0);
    checkWrites("p5", 'h40, 64, 0, 0);

    // Pass 5b: the mid-copy write kept block 1 dirty.
    startPass();
    finishPass("p5b", 500, 194, 1'b0);
    checkWrites("p5b", 'h40, 64, 0, 0);

    // Pass 6: extra syncs while busy are ignored.
    startPass();
    repeat (3) @(negedge clk);
    applyStimulus(KIND_SYNC, '0);
    repeat (40) @(negedge clk);
    applyStimulus(KIND_SYNC, '0);
    finishPass("p6", 500, 130, 1'b0);
    checkWrites("p6", 0, 0, 0, 0);
    repeat (200) @(negedge clk);
    #3;
    checkOutput("p6_singleDone", doneCnt - snapDone, 1);
    checkOutput("p6_idleBusy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
